// File: rtl/axi_pkg.sv
// AXI4 encodings and the line-writer state type shared across the memory-side blocks.
package axi_pkg;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_SEND   = 2'd1,
      WR_WAIT_B = 2'd2
   } wr_state_e;
endpackage

// File: rtl/config_pkg.sv
// User-level cache/bus geometry shared by the DCache datapath blocks.
package config_pkg;
   localparam int DCACHE_LINE_WIDTH = 256;
   localparam int AXI_DATA_W        = 64;
endpackage

// File: rtl/dcache_line_axi_writer.sv
// DCache writeback transmitter: one evicted line -> one AXI4 INCR burst, then waits for B.
// Exactly one burst in flight; completion is a single-cycle pulse carrying the error flag.
module dcache_line_axi_writer
   import axi_pkg::*;
#(
   parameter int LINE_WIDTH = config_pkg::DCACHE_LINE_WIDTH,
   parameter int AXI_DATA_W = config_pkg::AXI_DATA_W,
   parameter int ADDR_W     = 32,
   parameter int ID_W       = 4,
   parameter int AXI_ID     = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [ADDR_W-1:0]       req_addr_i,
   input  logic [LINE_WIDTH-1:0]   req_line_i,
   output logic                    done_valid_o,
   output logic                    done_err_o,
   output logic                    aw_valid_o,
   input  logic                    aw_ready_i,
   output logic [ADDR_W-1:0]       aw_addr_o,
   output logic [ID_W-1:0]         aw_id_o,
   output logic [7:0]              aw_len_o,
   output logic [2:0]              aw_size_o,
   output logic [1:0]              aw_burst_o,
   output logic                    w_valid_o,
   input  logic                    w_ready_i,
   output logic [AXI_DATA_W-1:0]   w_data_o,
   output logic [AXI_DATA_W/8-1:0] w_strb_o,
   output logic                    w_last_o,
   input  logic                    b_valid_i,
   output logic                    b_ready_o,
   input  logic [1:0]              b_resp_i
);
   localparam int BEATS  = LINE_WIDTH / AXI_DATA_W;
   localparam int CNT_W  = $clog2(BEATS) + 1;
   localparam int OFFS_W = $clog2(LINE_WIDTH / 8);
   localparam int SEL_W  = $clog2(LINE_WIDTH);
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'((64'd1 << OFFS_W) - 64'd1);

   wr_state_e             state;
   logic [ADDR_W-1:0]     addr_q;
   logic [LINE_WIDTH-1:0] line_q;
   logic [CNT_W-1:0]      cnt;
   logic                  aw_vld, aw_sent, w_vld, b_rdy, req_rdy, done_vld, done_err;

   logic             aw_hs, w_hs, is_last, aw_done, w_done, resp_err;
   logic [SEL_W-1:0] beat_lsb;

   assign aw_hs    = aw_vld & aw_ready_i;
   assign w_hs     = w_vld & w_ready_i;
   assign is_last  = (cnt == LAST_BEAT);
   assign aw_done  = aw_sent | aw_hs;
   // w_vld drops after the last beat, so a low w_vld inside SEND means all data is out
   assign w_done   = ~w_vld | (w_hs & is_last);
   assign resp_err = (b_resp_i == AXI_RESP_SLVERR) || (b_resp_i == AXI_RESP_DECERR);
   assign beat_lsb = SEL_W'(cnt) * SEL_W'(AXI_DATA_W);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= WR_IDLE;
         addr_q   <= '0;
         line_q   <= '0;
         cnt      <= '0;
         aw_vld   <= 1'b0;
         aw_sent  <= 1'b0;
         w_vld    <= 1'b0;
         b_rdy    <= 1'b0;
         req_rdy  <= 1'b0;
         done_vld <= 1'b0;
         done_err <= 1'b0;
      end else begin
         done_vld <= 1'b0;
         done_err <= 1'b0;
         case (state)
            WR_IDLE: begin
               if (req_valid_i && req_rdy) begin
                  addr_q  <= req_addr_i & ~OFFS_MASK;
                  line_q  <= req_line_i;
                  cnt     <= '0;
                  aw_sent <= 1'b0;
                  aw_vld  <= 1'b1;
                  w_vld   <= 1'b1;
                  req_rdy <= 1'b0;
                  state   <= WR_SEND;
               end else begin
                  // ready was held low through the done cycle; it returns one cycle later
                  req_rdy <= 1'b1;
               end
            end
            WR_SEND: begin
               if (aw_hs) begin
                  aw_vld  <= 1'b0;
                  aw_sent <= 1'b1;
               end
               if (w_hs) begin
                  if (is_last) w_vld <= 1'b0;
                  else         cnt   <= cnt + 1'b1;
               end
               if (aw_done && w_done) begin
                  b_rdy <= 1'b1;
                  state <= WR_WAIT_B;
               end
            end
            WR_WAIT_B: begin
               if (b_valid_i) begin
                  b_rdy    <= 1'b0;
                  done_vld <= 1'b1;
                  done_err <= resp_err;
                  state    <= WR_IDLE;
               end
            end
            default: state <= WR_IDLE;
         endcase
      end
   end

   assign req_ready_o  = req_rdy;
   assign done_valid_o = done_vld;
   assign done_err_o   = done_err;
   assign aw_valid_o   = aw_vld;
   assign aw_addr_o    = addr_q;
   assign aw_id_o      = ID_W'(AXI_ID);
   assign aw_len_o     = 8'(BEATS - 1);
   assign aw_size_o    = 3'($clog2(AXI_DATA_W / 8));
   assign aw_burst_o   = AXI_BURST_INCR;
   assign w_valid_o    = w_vld;
   assign w_data_o     = line_q[beat_lsb +: AXI_DATA_W];
   assign w_strb_o     = '1;
   assign w_last_o     = is_last;
   assign b_ready_o    = b_rdy;
endmodule

// File: tb/tb_dcache_line_axi_writer.sv
// Randomized bench for dcache_line_axi_writer: a transaction-level model of the burst
// (beats owed, AW owed, B owed, done owed) is checked against the DUT every cycle.
module tb_dcache_line_axi_writer;
   localparam int LW = 256;
   localparam int DW = 64;
   localparam int BEATS = LW / DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [31:0]   req_addr = '0;
   logic [LW-1:0] req_line = '0;
   logic          done_valid, done_err;
   logic          aw_valid, aw_ready = 1'b0;
   logic [31:0]   aw_addr;
   logic [3:0]    aw_id;
   logic [7:0]    aw_len;
   logic [2:0]    aw_size;
   logic [1:0]    aw_burst;
   logic          w_valid, w_ready = 1'b0;
   logic [DW-1:0] w_data;
   logic [7:0]    w_strb;
   logic          w_last;
   logic          b_valid = 1'b0, b_ready;
   logic [1:0]    b_resp = 2'b00;

   dcache_line_axi_writer #(.LINE_WIDTH(LW), .AXI_DATA_W(DW), .ADDR_W(32), .ID_W(4), .AXI_ID(1)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr), .req_line_i(req_line),
      .done_valid_o(done_valid), .done_err_o(done_err),
      .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr), .aw_id_o(aw_id),
      .aw_len_o(aw_len), .aw_size_o(aw_size), .aw_burst_o(aw_burst),
      .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb), .w_last_o(w_last),
      .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // slave-side ready/response knobs, set by the main sequence
   int aw_p = 100, w_p = 100, b_p = 100, force_resp = 0;
   bit w_toggle = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      aw_ready = (aw_p > int'($urandom_range(99)));
      w_ready  = w_toggle ? ~w_ready : (w_p > int'($urandom_range(99)));
      b_valid  = (b_p > int'($urandom_range(99)));
      b_resp   = (force_resp >= 0) ? 2'(force_resp) : 2'($urandom_range(3));
   end

   // transaction model: what is still owed for the burst in flight
   bit            m_out = 0, m_aw_done = 0, m_done_due = 0, m_err = 0, m_cool = 1;
   int            m_beats = 0;
   logic [31:0]   m_addr = '0;
   logic [LW-1:0] m_line = '0;
   logic [31:0]   last_aw_addr = '0;
   logic [DW-1:0] first_wdata = '0, last_wdata = '0;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_req_ready", req_ready, 0);
         chk("rst_aw_valid", aw_valid, 0);
         chk("rst_w_valid", w_valid, 0);
         chk("rst_b_ready", b_ready, 0);
         chk("rst_done_valid", done_valid, 0);
         m_out = 0; m_aw_done = 0; m_beats = 0; m_done_due = 0; m_cool = 1;
      end else begin
         chk("req_ready", req_ready, !m_out && !m_done_due && !m_cool);
         chk("aw_valid", aw_valid, m_out && !m_aw_done);
         if (aw_valid) begin
            chk("aw_addr", aw_addr, m_addr & ~32'h1F);
            chk("aw_id", aw_id, 4'd1);
            chk("aw_len", aw_len, 8'(BEATS - 1));
            chk("aw_size", aw_size, 3'd3);
            chk("aw_burst", aw_burst, 2'b01);
         end
         chk("w_valid", w_valid, m_out && m_beats < BEATS);
         if (w_valid && m_beats < BEATS) begin
            chk("w_data", w_data, m_line[m_beats*DW +: DW]);
            chk("w_last", w_last, m_beats == BEATS - 1);
            chk("w_strb", w_strb, 8'hFF);
         end
         chk("b_ready", b_ready, m_out && m_aw_done && m_beats == BEATS);
         chk("done_valid", done_valid, m_done_due);
         if (m_done_due) chk("done_err", done_err, m_err);
         m_cool = 0;
         m_done_due = 0;
         if (req_valid && req_ready) begin
            m_out = 1; m_aw_done = 0; m_beats = 0; m_addr = req_addr; m_line = req_line;
         end
         if (aw_valid && aw_ready) begin
            m_aw_done = 1;
            last_aw_addr = aw_addr;
         end
         if (w_valid && w_ready) begin
            if (m_beats == 0) first_wdata = w_data;
            if (w_last) last_wdata = w_data;
            m_beats++;
         end
         if (b_ready && b_valid) begin
            m_out = 0; m_done_due = 1; m_err = b_resp[1];
         end
      end
   end

   task automatic send_req(input logic [31:0] a, input logic [LW-1:0] l, input bit hold, output int acc);
      bit got = 0;
      req_addr = a; req_line = l; req_valid = 1'b1; acc = -1;
      for (int n = 0; n < 2000 && !got; n++) begin
         @(negedge clk);
         if (req_ready) begin got = 1; acc = cyc; end
      end
      if (!got) chk("req_accept_timeout", 0, 1);
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic wait_done(output bit err, output int dcyc);
      bit got = 0;
      err = 0; dcyc = -1;
      for (int n = 0; n < 2000 && !got; n++) begin
         @(negedge clk);
         if (done_valid) begin got = 1; err = done_err; dcyc = cyc; end
      end
      if (!got) chk("done_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] l;
      for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   initial begin
      logic [LW-1:0] basic_line;
      bit            err;
      int            acc, acc2, dcyc, n;
      bit [1:0]      resp_tab[4];
      bit            err_tab[4];

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // basic burst, all ready
      basic_line = {64'hCAFEF00D00000003, 64'hDEADBEEF00000002, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
      aw_p = 100; w_p = 100; b_p = 100; force_resp = 0;
      send_req(32'h8000_1234, basic_line, 0, acc);
      wait_done(err, dcyc);
      chk("basic_aw_addr", last_aw_addr, 32'h8000_1220);
      chk("basic_first_beat", first_wdata, 64'h0123456789ABCDEF);
      chk("basic_last_beat", last_wdata, 64'hCAFEF00D00000003);
      chk("basic_done_err", err, 0);
      chk("basic_latency", dcyc - acc - 1, BEATS + 1);

      // spurious B while idle must not complete anything
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done_valid) n++;
      end
      chk("spurious_b_done", n, 0);
      @(posedge clk); #1;

      // W ahead of AW
      aw_p = 0; w_p = 100;
      send_req(32'h0000_4040, rand_line(), 0, acc);
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("w_first_w_valid", w_valid, 0);
      chk("w_first_aw_valid", aw_valid, 1);
      chk("w_first_b_ready", b_ready, 0);
      @(posedge clk); #1;
      aw_p = 100;
      wait_done(err, dcyc);
      chk("w_first_aw_addr", last_aw_addr, 32'h0000_4040);

      // toggling W backpressure
      w_toggle = 1'b1;
      send_req(32'hABCD_00FF, rand_line(), 0, acc);
      wait_done(err, dcyc);
      w_toggle = 1'b0;

      // response decoding
      resp_tab = '{2'b10, 2'b11, 2'b01, 2'b00};
      err_tab  = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         force_resp = int'(resp_tab[i]);
         send_req($urandom, rand_line(), 0, acc);
         wait_done(err, dcyc);
         chk($sformatf("resp_%0d_err", resp_tab[i]), err, err_tab[i]);
      end
      force_resp = 0;

      // reset in the middle of a burst, then a fresh request
      aw_p = 0; w_p = 100;
      send_req(32'h5555_5500, rand_line(), 0, acc);
      for (int i = 0; i < 50 && m_beats < 2; i++) @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_w_valid", w_valid, 0);
      chk("midrst_aw_valid", aw_valid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_req_ready", req_ready, 1);
      @(posedge clk); #1;
      aw_p = 100;
      send_req(32'h1234_5678, basic_line, 0, acc);
      wait_done(err, dcyc);
      chk("midrst_new_addr", last_aw_addr, 32'h1234_5660);
      chk("midrst_new_beat0", first_wdata, 64'h0123456789ABCDEF);

      // back-to-back with valid held
      send_req(32'h0000_1000, rand_line(), 1, acc);
      send_req(32'h0000_2000, rand_line(), 0, acc2);
      chk("b2b_gap", (acc2 > acc + BEATS + 1), 1);
      wait_done(err, dcyc);

      // randomized traffic
      force_resp = -1;
      for (int t = 0; t < 30; t++) begin
         aw_p = int'($urandom_range(20, 100));
         w_p  = int'($urandom_range(20, 100));
         b_p  = int'($urandom_range(20, 100));
         w_toggle = ($urandom_range(3) == 0);
         send_req($urandom, rand_line(), 0, acc);
         wait_done(err, dcyc);
         repeat ($urandom_range(2)) @(posedge clk);
         #1;
      end
      w_toggle = 1'b0;
      repeat (4) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
